// File: rtl/fft_pkg.sv
// Shared constants, state encoding and peak record for the FFT peak picker.
package fft_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned N_BINS  = 1024;
  localparam int unsigned IDX_W   = 10;
  localparam int unsigned MAG_W   = DATA_W + 1;
  localparam int unsigned MIN_BIN = 1;
  localparam int unsigned MAX_BIN = 511;
  localparam int unsigned GUARD   = 2;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StFlush,
    StDone
  } state_e;

  typedef struct packed {
    logic [MAG_W-1:0] mag;
    logic [IDX_W-1:0] idx;
  } peak_t;

  function automatic logic [IDX_W-1:0] idx_dist(input logic [IDX_W-1:0] a,
                                                input logic [IDX_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/fft_peak_pick_mag_approx.sv
// Two-stage registered magnitude estimate max(|re|,|im|) + min(|re|,|im|)/2,
// with index and tag carried alongside the data.
module mag_approx #(
  parameter int unsigned DataW = 16,
  parameter int unsigned IdxW  = 10,
  parameter int unsigned TagW  = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    valid_i,
  input  logic signed [DataW-1:0] re_i,
  input  logic signed [DataW-1:0] im_i,
  input  logic [IdxW-1:0]         idx_i,
  input  logic [TagW-1:0]         tag_i,
  output logic                    valid_o,
  output logic [DataW:0]          mag_o,
  output logic [IdxW-1:0]         idx_o,
  output logic [TagW-1:0]         tag_o
);

  logic [DataW-1:0] a_d, b_d, a_q, b_q, hi, lo;
  logic [DataW:0]   mag_d;
  logic             v1_q;
  logic [IdxW-1:0]  idx1_q;
  logic [TagW-1:0]  tag1_q;

  // Two's-complement negate in DataW bits: the most negative input maps to
  // 2^(DataW-1) as an unsigned value without saturating.
  always_comb begin
    a_d = re_i[DataW-1] ? DataW'(~re_i + 1'b1) : DataW'($unsigned(re_i));
    b_d = im_i[DataW-1] ? DataW'(~im_i + 1'b1) : DataW'($unsigned(im_i));
  end

  always_comb begin
    hi    = (a_q >= b_q) ? a_q : b_q;
    lo    = (a_q >= b_q) ? b_q : a_q;
    mag_d = {1'b0, hi} + {2'b00, lo[DataW-1:1]};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q     <= '0;
      b_q     <= '0;
      v1_q    <= 1'b0;
      idx1_q  <= '0;
      tag1_q  <= '0;
      valid_o <= 1'b0;
      mag_o   <= '0;
      idx_o   <= '0;
      tag_o   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      v1_q    <= valid_i;
      idx1_q  <= idx_i;
      tag1_q  <= tag_i;
      valid_o <= v1_q;
      mag_o   <= mag_d;
      idx_o   <= idx1_q;
      tag_o   <= tag1_q;
    end
  end

endmodule

// File: rtl/fft_peak_pick.sv
// Tracks the two strongest non-adjacent bins of each FFT frame inside a bin
// window and presents them once per frame.
module fft_peak_pick
  import fft_pkg::*;
#(
  parameter int unsigned MinBin = MIN_BIN,
  parameter int unsigned MaxBin = MAX_BIN,
  parameter int unsigned Guard  = GUARD
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     fft_sop,
  input  logic                     fft_eop,
  input  logic                     fft_valid,
  input  logic signed [DATA_W-1:0] fft_real,
  input  logic signed [DATA_W-1:0] fft_imag,
  output logic                     busy,
  output logic                     result_valid,
  output logic [IDX_W-1:0]         peak1_idx,
  output logic [MAG_W-1:0]         peak1_mag,
  output logic [IDX_W-1:0]         peak2_idx,
  output logic [MAG_W-1:0]         peak2_mag,
  output logic                     peak2_ok,
  output logic                     frame_err
);

  state_e           state_q, state_d;
  logic             in_frame_q, in_frame_d;
  logic [IDX_W-1:0] idx_q, idx_d, cur_idx;
  logic             frame_err_q, frame_err_d;
  logic [1:0]       flush_cnt_q, flush_cnt_d;
  logic             accept, at_last_bin, last;

  assign accept      = fft_valid & (fft_sop | in_frame_q);
  assign cur_idx     = fft_sop ? '0 : idx_q;
  assign at_last_bin = (cur_idx == IDX_W'(N_BINS - 1));
  assign last        = accept & (fft_eop | at_last_bin);

  // Input framing runs independently of the FSM so a sop can open a new
  // frame while the previous one is still draining.
  always_comb begin
    in_frame_d  = in_frame_q;
    idx_d       = idx_q;
    frame_err_d = frame_err_q;
    if (accept) begin
      idx_d      = cur_idx + 1'b1;
      in_frame_d = ~last;
      if (fft_sop) frame_err_d = 1'b0;
      if (fft_eop != at_last_bin) frame_err_d = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= StIdle;
      in_frame_q  <= 1'b0;
      idx_q       <= '0;
      frame_err_q <= 1'b0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      in_frame_q  <= in_frame_d;
      idx_q       <= idx_d;
      frame_err_q <= frame_err_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = '0;
    unique case (state_q)
      StIdle:  if (accept) state_d = last ? StFlush : StAccum;
      StAccum: if (last) state_d = StFlush;
      StFlush: begin
        flush_cnt_d = flush_cnt_q + 2'd1;
        if (flush_cnt_q == 2'd2) state_d = StDone;
      end
      StDone:  state_d = in_frame_d ? StAccum : StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q != StIdle);
  end

  // Pipeline tag: bit 1 = sop (clear trackers), bit 0 = last bin of frame.
  logic             v2;
  logic [MAG_W-1:0] mag2;
  logic [IDX_W-1:0] idx2;
  logic [1:0]       tag2;

  mag_approx #(
    .DataW (DATA_W),
    .IdxW  (IDX_W),
    .TagW  (2)
  ) u_mag (
    .clk_i   (sys_clk),
    .rst_i   (sys_rst),
    .valid_i (accept),
    .re_i    (fft_real),
    .im_i    (fft_imag),
    .idx_i   (cur_idx),
    .tag_i   ({fft_sop, last}),
    .valid_o (v2),
    .mag_o   (mag2),
    .idx_o   (idx2),
    .tag_o   (tag2)
  );

  peak_t p1_q, p2_q, p1_d, p2_d, base1, base2, snap1_q, snap2_q;
  logic  far, in_win;

  always_comb begin
    base1  = (v2 && tag2[1]) ? '0 : p1_q;
    base2  = (v2 && tag2[1]) ? '0 : p2_q;
    p1_d   = base1;
    p2_d   = base2;
    far    = idx_dist(idx2, base1.idx) > IDX_W'(Guard);
    in_win = (idx2 >= IDX_W'(MinBin)) && (idx2 <= IDX_W'(MaxBin));
    if (v2 && in_win) begin
      if (mag2 > base1.mag) begin
        p1_d = '{mag: mag2, idx: idx2};
        if (far) p2_d = base1;
      end else if ((mag2 > base2.mag) && far) begin
        p2_d = '{mag: mag2, idx: idx2};
      end
    end
  end

  // The snapshot freezes the finished frame so a following frame can
  // reuse the trackers before the result is presented.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      p1_q    <= '0;
      p2_q    <= '0;
      snap1_q <= '0;
      snap2_q <= '0;
    end else begin
      p1_q <= p1_d;
      p2_q <= p2_d;
      if (v2 && tag2[0]) begin
        snap1_q <= p1_d;
        snap2_q <= p2_d;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      result_valid <= 1'b0;
      peak1_idx    <= '0;
      peak1_mag    <= '0;
      peak2_idx    <= '0;
      peak2_mag    <= '0;
      peak2_ok     <= 1'b0;
    end else begin
      result_valid <= (state_q == StDone);
      if (state_q == StDone) begin
        peak1_idx <= snap1_q.idx;
        peak1_mag <= snap1_q.mag;
        peak2_idx <= snap2_q.idx;
        peak2_mag <= snap2_q.mag;
        peak2_ok  <= (snap2_q.mag != '0) &&
                     (idx_dist(snap2_q.idx, snap1_q.idx) > IDX_W'(Guard));
      end
    end
  end

  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_fft_peak_pick.sv
// Self-checking bench for fft_peak_pick: directed vector table, hand-written
// framing/reset sequences and random frames against a frame-level model.
module tb_fft_peak_pick;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               sop = 1'b0, eop = 1'b0, valid = 1'b0;
  logic signed [15:0] re = '0, im = '0;
  logic               busy, result_valid, peak2_ok, frame_err;
  logic [9:0]         peak1_idx, peak2_idx;
  logic [16:0]        peak1_mag, peak2_mag;

  fft_peak_pick dut (
    .sys_clk      (clk),
    .sys_rst      (rst),
    .fft_sop      (sop),
    .fft_eop      (eop),
    .fft_valid    (valid),
    .fft_real     (re),
    .fft_imag     (im),
    .busy         (busy),
    .result_valid (result_valid),
    .peak1_idx    (peak1_idx),
    .peak1_mag    (peak1_mag),
    .peak2_idx    (peak2_idx),
    .peak2_mag    (peak2_mag),
    .peak2_ok     (peak2_ok),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int p1i; int p1m; int p2i; int p2m; bit ok; bit err;
  } exp_t;

  typedef struct {
    int cyc; int p1i; int p1m; int p2i; int p2m; bit ok; bit err;
  } res_t;

  typedef struct {
    string name;
    int    nt;
    int    ti[4];
    int    tr[4];
    int    tq[4];
    int    last;
    bit    with_eop;
    exp_t  e;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   fr_re[1024];
  int   fr_im[1024];
  res_t resq[$];
  vec_t vecs[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (result_valid)
      resq.push_back('{cyc: cyc, p1i: int'(peak1_idx), p1m: int'(peak1_mag),
                       p2i: int'(peak2_idx), p2m: int'(peak2_mag),
                       ok: peak2_ok, err: frame_err});
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int absi(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int magf(input int r, input int q);
    int a, b;
    a = absi(r);
    b = absi(q);
    return (a > b) ? a + b / 2 : b + a / 2;
  endfunction

  // Frame-level reference: walk the bins in arrival order applying the
  // peak rules on plain integers.
  function automatic exp_t model(input int last, input bit with_eop);
    exp_t e;
    int   m, d;
    e = '{default: 0};
    for (int i = 1; i <= last && i <= 511; i++) begin
      m = magf(fr_re[i], fr_im[i]);
      d = absi(i - e.p1i);
      if (m > e.p1m) begin
        if (d > 2) begin
          e.p2m = e.p1m;
          e.p2i = e.p1i;
        end
        e.p1m = m;
        e.p1i = i;
      end else if (m > e.p2m && d > 2) begin
        e.p2m = m;
        e.p2i = i;
      end
    end
    e.ok  = (e.p2m != 0) && (absi(e.p2i - e.p1i) > 2);
    e.err = (with_eop && last != 1023) || (!with_eop && last == 1023);
    return e;
  endfunction

  task automatic clear_frame();
    for (int i = 0; i < 1024; i++) begin
      fr_re[i] = 0;
      fr_im[i] = 0;
    end
  endtask

  task automatic send_frame(input int last, input bit with_eop, input bit gaps,
                            output int eop_cyc);
    for (int i = 0; i <= last; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          valid = 1'b0;
          sop   = 1'($urandom);
          eop   = 1'($urandom);
          re    = 16'($urandom);
          im    = 16'($urandom);
          tick();
        end
      end
      valid = 1'b1;
      sop   = (i == 0);
      eop   = with_eop && (i == last);
      re    = 16'(fr_re[i]);
      im    = 16'(fr_im[i]);
      tick();
    end
    eop_cyc = cyc;
    valid = 1'b0;
    sop   = 1'b0;
    eop   = 1'b0;
  endtask

  task automatic expect_result(input string name, input int exp_cyc, input exp_t e,
                               input bit idle_after);
    res_t r;
    int   n = 0;
    while (resq.size() == 0 && n < 40) begin
      tick();
      n++;
    end
    if (resq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no result_valid expected one", name);
      return;
    end
    r = resq.pop_front();
    chk({name, "_latency_cyc"}, r.cyc, exp_cyc);
    chk({name, "_p1_idx"}, r.p1i, e.p1i);
    chk({name, "_p1_mag"}, r.p1m, e.p1m);
    chk({name, "_p2_idx"}, r.p2i, e.p2i);
    chk({name, "_p2_mag"}, r.p2m, e.p2m);
    chk({name, "_p2_ok"}, int'(r.ok), int'(e.ok));
    chk({name, "_frame_err"}, int'(r.err), int'(e.err));
    if (idle_after) begin
      tick();
      tick();
      chk({name, "_rv_low"}, int'(result_valid), 0);
      chk({name, "_busy_low"}, int'(busy), 0);
      chk({name, "_hold_p1"}, int'(peak1_idx), e.p1i);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_rv"}, int'(result_valid), 0);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_p1i"}, int'(peak1_idx), 0);
    chk({name, "_p1m"}, int'(peak1_mag), 0);
    chk({name, "_p2i"}, int'(peak2_idx), 0);
    chk({name, "_p2m"}, int'(peak2_mag), 0);
    chk({name, "_ok"}, int'(peak2_ok), 0);
    chk({name, "_err"}, int'(frame_err), 0);
  endtask

  initial begin
    int   c, ca, cb;
    exp_t ea, eb;

    vecs.push_back('{name: "single", nt: 1, ti: '{100, 0, 0, 0}, tr: '{1000, 0, 0, 0},
                     tq: '{0, 0, 0, 0}, last: 1023, with_eop: 1'b1,
                     e: '{p1i: 100, p1m: 1000, p2i: 0, p2m: 0, ok: 1'b0, err: 1'b0}});
    vecs.push_back('{name: "two_tones", nt: 2, ti: '{50, 200, 0, 0},
                     tr: '{300, -600, 0, 0}, tq: '{400, 0, 0, 0}, last: 1023, with_eop: 1'b1,
                     e: '{p1i: 200, p1m: 600, p2i: 50, p2m: 550, ok: 1'b1, err: 1'b0}});
    vecs.push_back('{name: "guard_window", nt: 4, ti: '{100, 101, 0, 700},
                     tr: '{1000, 900, 5000, 4000}, tq: '{0, 0, 0, 0}, last: 1023,
                     with_eop: 1'b1,
                     e: '{p1i: 100, p1m: 1000, p2i: 0, p2m: 0, ok: 1'b0, err: 1'b0}});
    vecs.push_back('{name: "extreme_tie", nt: 2, ti: '{10, 20, 0, 0},
                     tr: '{-32768, -32768, 0, 0}, tq: '{-32768, -32768, 0, 0}, last: 1023,
                     with_eop: 1'b1,
                     e: '{p1i: 10, p1m: 49152, p2i: 20, p2m: 49152, ok: 1'b1, err: 1'b0}});
    vecs.push_back('{name: "eop_511", nt: 1, ti: '{100, 0, 0, 0}, tr: '{1000, 0, 0, 0},
                     tq: '{0, 0, 0, 0}, last: 511, with_eop: 1'b1,
                     e: '{p1i: 100, p1m: 1000, p2i: 0, p2m: 0, ok: 1'b0, err: 1'b1}});
    vecs.push_back('{name: "no_eop", nt: 1, ti: '{300, 0, 0, 0}, tr: '{0, 0, 0, 0},
                     tq: '{-700, 0, 0, 0}, last: 1023, with_eop: 1'b0,
                     e: '{p1i: 300, p1m: 700, p2i: 0, p2m: 0, ok: 1'b0, err: 1'b1}});
    vecs.push_back('{name: "window_edges", nt: 3, ti: '{1, 511, 512, 0},
                     tr: '{50, 100, 5000, 0}, tq: '{50, 0, 0, 0}, last: 1023, with_eop: 1'b1,
                     e: '{p1i: 511, p1m: 100, p2i: 1, p2m: 75, ok: 1'b1, err: 1'b0}});
    vecs.push_back('{name: "guard_edge", nt: 3, ti: '{100, 102, 103, 0},
                     tr: '{1000, 600, 500, 0}, tq: '{0, 0, 0, 0}, last: 1023, with_eop: 1'b1,
                     e: '{p1i: 100, p1m: 1000, p2i: 103, p2m: 500, ok: 1'b1, err: 1'b0}});
    vecs.push_back('{name: "guard_replace", nt: 2, ti: '{100, 101, 0, 0},
                     tr: '{900, 1000, 0, 0}, tq: '{0, 0, 0, 0}, last: 1023, with_eop: 1'b1,
                     e: '{p1i: 101, p1m: 1000, p2i: 0, p2m: 0, ok: 1'b0, err: 1'b0}});

    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    foreach (vecs[k]) begin
      clear_frame();
      for (int t = 0; t < vecs[k].nt; t++) begin
        fr_re[vecs[k].ti[t]] = vecs[k].tr[t];
        fr_im[vecs[k].ti[t]] = vecs[k].tq[t];
      end
      send_frame(vecs[k].last, vecs[k].with_eop, k % 2 == 1, c);
      expect_result(vecs[k].name, c + 4, vecs[k].e, 1'b1);
    end

    // Restart by sop mid-frame: the aborted frame's stronger tone must vanish.
    clear_frame();
    fr_re[100] = 8000;
    send_frame(299, 1'b0, 1'b0, c);
    chk("abort_busy", int'(busy), 1);
    clear_frame();
    fr_re[200] = 1000;
    send_frame(1023, 1'b1, 1'b0, c);
    expect_result("abort", c + 4, '{p1i: 200, p1m: 1000, p2i: 0, p2m: 0, ok: 1'b0,
                                    err: 1'b0}, 1'b1);
    chk("abort_extra_results", resq.size(), 0);

    // Back-to-back frames: new sop lands while the previous frame drains.
    clear_frame();
    fr_im[60] = 2000;
    fr_re[300] = -1200;
    ea = model(1023, 1'b1);
    send_frame(1023, 1'b1, 1'b0, ca);
    clear_frame();
    fr_re[400] = 1500;
    fr_im[400] = 1500;
    eb = model(1023, 1'b1);
    send_frame(1023, 1'b1, 1'b0, cb);
    expect_result("b2b_a", ca + 4, ea, 1'b0);
    expect_result("b2b_b", cb + 4, eb, 1'b1);

    // Reset asserted mid-frame discards everything.
    clear_frame();
    fr_re[100] = 3000;
    send_frame(400, 1'b0, 1'b0, c);
    rst = 1'b1;
    tick();
    tick();
    chk_all_zero("rst_mid");
    rst = 1'b0;
    tick();
    chk("rst_no_result", resq.size(), 0);
    clear_frame();
    fr_re[100] = 1000;
    send_frame(1023, 1'b1, 1'b0, c);
    expect_result("after_rst", c + 4, '{p1i: 100, p1m: 1000, p2i: 0, p2m: 0, ok: 1'b0,
                                        err: 1'b0}, 1'b1);

    // Random frames: low noise floor plus a few strong random tones.
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 1024; i++) begin
        fr_re[i] = int'($urandom_range(0, 200)) - 100;
        fr_im[i] = int'($urandom_range(0, 200)) - 100;
      end
      for (int t = 0; t < 4; t++) begin
        c = int'($urandom_range(0, 1023));
        fr_re[c] = (t == 0 && f == 3) ? -32768 : int'($urandom_range(0, 65535)) - 32768;
        fr_im[c] = int'($urandom_range(0, 65535)) - 32768;
      end
      ea = model(1023, 1'b1);
      send_frame(1023, 1'b1, f % 2 == 1, c);
      expect_result($sformatf("rand%0d", f), c + 4, ea, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
